// File: rtl/fft_twiddle_addr_gen_if.sv
// Handshake/bus bundle between the FFT twiddle sequencer and the butterfly unit.
// master: sequencer (drives tw_addr, bf_*, busy, done); slave: consumer (drives start, ready).
interface fft_twiddle_addr_gen_if #(
   parameter int LOG2N  = 5,
   parameter int ADDR_W = 5
);
   logic              start;
   logic              ready;
   logic [ADDR_W-1:0] tw_addr;
   logic              bf_valid;
   logic [LOG2N-1:0]  bf_idx_a;
   logic [LOG2N-1:0]  bf_idx_b;
   logic [2:0]        bf_stage;
   logic              busy;
   logic              done;

   modport master (
      input  start, ready,
      output tw_addr, bf_valid, bf_idx_a, bf_idx_b,
      output bf_stage, busy, done
   );

   modport slave (
      output start, ready,
      input  tw_addr, bf_valid, bf_idx_a, bf_idx_b,
      input  bf_stage, busy, done
   );
endinterface

// File: rtl/fft_twiddle_addr_gen.sv
// Radix-2 DIT FFT sequencer: walks stages/butterflies, drives the twiddle ROM address
// and emits operand indices delayed one cycle to line up with registered ROM data.
// Ports: clk, rst_n (async, active-low), bus (master: start/ready in; tw_addr, bf_*, busy, done out).
module fft_twiddle_addr_gen #(
   parameter int LOG2N     = 5,
   parameter int ADDR_W    = 5,
   parameter int STAGE_GAP = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   fft_twiddle_addr_gen_if.master bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_GAP  = 2'd2;

   localparam int BW = LOG2N - 1;
   localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
   localparam logic [2:0] S_LAST = 3'(LOG2N - 1);
   localparam logic [GW-1:0] G_LAST =
      GW'((STAGE_GAP > 0) ? STAGE_GAP - 1 : 0);

   logic [1:0]    state;
   logic [2:0]    s;
   logic [BW-1:0] b;
   logic [GW-1:0] g;

   logic issue, accept, b_last, s_last, fin;

   logic [LOG2N-1:0]  half, bx, p, j, idx_a, idx_b;
   logic [3:0]        sh_tw;
   logic [ADDR_W-1:0] tw;

   logic             valid_q, busy_q, done_q;
   logic [LOG2N-1:0] idx_a_q, idx_b_q;
   logic [2:0]       stage_q;

   // busy also covers the done cycle, so a start there is ignored
   assign accept = (state == S_IDLE) && bus.start && !busy_q;
   assign issue  = (state == S_RUN) && bus.ready;
   assign b_last = &b;
   assign s_last = (s == S_LAST);
   assign fin    = issue && b_last && s_last;

   // butterfly b of stage s: group j, offset p within the group
   always_comb begin
      half  = LOG2N'(1) << s;
      bx    = LOG2N'(b);
      p     = bx & (half - 1'b1);
      j     = bx >> s;
      idx_a = (j << (4'(s) + 4'd1)) | p;
      idx_b = idx_a + half;
      sh_tw = 4'(S_LAST) - 4'(s);
      tw    = ADDR_W'(p) << sh_tw;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         s     <= '0;
         b     <= '0;
         g     <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (accept) begin
                  state <= S_RUN;
                  s     <= '0;
                  b     <= '0;
                  g     <= '0;
               end
            end
            S_RUN: begin
               if (issue) begin
                  b <= b + 1'b1;
                  if (b_last) begin
                     if (s_last) begin
                        state <= S_IDLE;
                        s     <= '0;
                     end else if (STAGE_GAP == 0) begin
                        s <= s + 3'd1;
                     end else begin
                        state <= S_GAP;
                     end
                  end
               end
            end
            S_GAP: begin
               // gap length is fixed; ready is not consulted here
               if (g == G_LAST) begin
                  g     <= '0;
                  s     <= s + 3'd1;
                  state <= S_RUN;
               end else begin
                  g <= g + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // one-cycle delay so indices coincide with the registered ROM output
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         idx_a_q <= '0;
         idx_b_q <= '0;
         stage_q <= '0;
      end else begin
         valid_q <= issue;
         done_q  <= fin;
         if (accept)
            busy_q <= 1'b1;
         else if (done_q)
            busy_q <= 1'b0;
         if (issue) begin
            idx_a_q <= idx_a;
            idx_b_q <= idx_b;
            stage_q <= s;
         end
      end
   end

   assign bus.tw_addr  = tw;
   assign bus.bf_valid = valid_q;
   assign bus.bf_idx_a = idx_a_q;
   assign bus.bf_idx_b = idx_b_q;
   assign bus.bf_stage = stage_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
endmodule

// File: tb/tb_fft_twiddle_addr_gen.sv
// Self-checking bench for fft_twiddle_addr_gen: queue scoreboard of expected butterflies,
// registered twiddle ROM model, extra instances with STAGE_GAP=0 and 3 for timing.
module tb_fft_twiddle_addr_gen;
   localparam int LOG2N = 5;
   localparam int NH    = 16;
   localparam int GAP   = 2;

   typedef struct packed {
      logic [4:0] a;
      logic [4:0] b;
      logic [2:0] s;
      logic [4:0] tw;
      logic       last;
   } exp_t;

   logic clk;
   logic rst_n;

   fft_twiddle_addr_gen_if #(.LOG2N(5), .ADDR_W(5)) bus ();
   fft_twiddle_addr_gen_if #(.LOG2N(5), .ADDR_W(5)) bus0 ();
   fft_twiddle_addr_gen_if #(.LOG2N(5), .ADDR_W(5)) bus3 ();

   fft_twiddle_addr_gen #(.LOG2N(5), .ADDR_W(5), .STAGE_GAP(2)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );
   fft_twiddle_addr_gen #(.LOG2N(5), .ADDR_W(5), .STAGE_GAP(0)) dut_g0 (
      .clk(clk), .rst_n(rst_n), .bus(bus0)
   );
   fft_twiddle_addr_gen #(.LOG2N(5), .ADDR_W(5), .STAGE_GAP(3)) dut_g3 (
      .clk(clk), .rst_n(rst_n), .bus(bus3)
   );

   assign bus0.start = bus.start;
   assign bus0.ready = 1'b1;
   assign bus3.start = bus.start;
   assign bus3.ready = 1'b1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_total = 0;
   int n_pass  = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
      n_total++;
      if (act === exp_v) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
   endtask

   // twiddle ROM contents (arbitrary distinct words per address)
   logic [15:0] tab_re [0:31];
   logic [15:0] tab_im [0:31];
   logic [15:0] rom_re, rom_im;
   logic [4:0]  tw_prev;

   always @(posedge clk) begin
      rom_re  <= tab_re[bus.tw_addr];
      rom_im  <= tab_im[bus.tw_addr];
      tw_prev <= bus.tw_addr;
   end

   exp_t q[$];
   exp_t me;
   logic [4:0] cap_a [0:127];
   logic [4:0] cap_b [0:127];
   logic [4:0] cap_tw [0:127];
   logic [2:0] cap_s [0:127];
   int cap_n;

   bit go;
   int cyc;
   int g0_cyc, g3_cyc;

   always @(posedge clk) cyc <= go ? 1 : cyc + 1;

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus0.done) g0_cyc = cyc;
         if (bus3.done) g3_cyc = cyc;
      end
   end

   // monitor: pop and compare on every bf_valid cycle
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.bf_valid) begin
            if (q.size() == 0) begin
               chk("unexpected_valid", 64'(bus.bf_idx_a), 64'hdead);
            end else begin
               me = q.pop_front();
               chk("bf", {bus.bf_idx_a, bus.bf_idx_b, bus.bf_stage, tw_prev, bus.done},
                   {me.a, me.b, me.s, me.tw, me.last});
               chk("rom", {rom_re, rom_im}, {tab_re[me.tw], tab_im[me.tw]});
               if (cap_n < 128) begin
                  cap_a[cap_n]  = bus.bf_idx_a;
                  cap_b[cap_n]  = bus.bf_idx_b;
                  cap_tw[cap_n] = tw_prev;
                  cap_s[cap_n]  = bus.bf_stage;
                  cap_n++;
               end
            end
         end else if (bus.done) begin
            chk("done_without_valid", 64'(bus.done), 64'd0);
         end
      end
   end

   task automatic run(input bit stall, input bit pk_busy, input bit pk_done, input int abort_t);
      int t, half;
      bit rdy, stl_prev;
      logic [4:0] hold_tw;
      exp_t e;
      stl_prev = 1'b0;
      hold_tw  = '0;
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.ready = 1'b1;
      go = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      go = 1'b0;
      t = 1;
      for (int s = 0; s < LOG2N; s++) begin
         half = 1 << s;
         for (int j = 0; j < NH / half; j++) begin
            for (int p = 0; p < half; p++) begin
               e.a    = 5'(j * 2 * half + p);
               e.b    = 5'(j * 2 * half + p + half);
               e.s    = 3'(s);
               e.tw   = 5'(p * (NH / half));
               e.last = (s == LOG2N - 1) && (j == NH / half - 1) && (p == half - 1);
               do begin
                  if (abort_t > 0 && t == abort_t) begin
                     rst_n = 1'b0;
                     #1;
                     chk("reset_outputs",
                         {bus.tw_addr, bus.bf_valid, bus.bf_idx_a, bus.bf_idx_b,
                          bus.bf_stage, bus.busy, bus.done}, 64'd0);
                     q.delete();
                     bus.start = 1'b0;
                     @(posedge clk); #1;
                     rst_n = 1'b1;
                     return;
                  end
                  rdy = stall ? ($urandom_range(0, 9) >= 3) : 1'b1;
                  bus.ready = rdy;
                  bus.start = pk_busy && (t == 40);
                  if (rdy) q.push_back(e);
                  @(negedge clk);
                  if (stl_prev) chk("tw_hold", 64'(bus.tw_addr), 64'(hold_tw));
                  if (!rdy) hold_tw = bus.tw_addr;
                  stl_prev = !rdy;
                  if (t == 1) chk("busy_first", 64'(bus.busy), 64'd1);
                  @(posedge clk); #1;
                  t++;
               end while (!rdy);
            end
         end
         if (s < LOG2N - 1) begin
            for (int g = 0; g < GAP; g++) begin
               bus.ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
               bus.start = 1'b0;
               @(posedge clk); #1;
               t++;
            end
         end
      end
      bus.ready = 1'b1;
      bus.start = pk_done;
      @(negedge clk);
      chk("done_cycle", {bus.done, bus.busy}, 64'b11);
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(negedge clk);
      chk("after_done", {bus.done, bus.busy}, 64'b00);
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("stays_idle", 64'(bus.busy), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit");
      $fatal(1);
   end

   initial begin
      for (int k = 0; k < 32; k++) begin
         tab_re[k] = 16'(16'h1000 + k * 37);
         tab_im[k] = 16'(16'h8000 - k * 91);
      end
      rst_n = 1'b0;
      bus.start = 1'b0;
      bus.ready = 1'b0;
      go = 1'b0;
      cap_n = 0;
      g0_cyc = -1;
      g3_cyc = -1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_state",
          {bus.tw_addr, bus.bf_valid, bus.bf_idx_a, bus.bf_idx_b,
           bus.bf_stage, bus.busy, bus.done}, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);

      // full unstalled run
      cap_n = 0;
      run(1'b0, 1'b0, 1'b0, 0);
      chk("bf_count", 64'(cap_n), 64'd80);
      chk("s0_b0", {cap_a[0], cap_b[0], cap_tw[0], cap_s[0]},
          {5'd0, 5'd1, 5'd0, 3'd0});
      chk("s0_b1", {cap_a[1], cap_b[1], cap_tw[1], cap_s[1]},
          {5'd2, 5'd3, 5'd0, 3'd0});
      chk("s2_b5", {cap_a[37], cap_b[37], cap_tw[37], cap_s[37]},
          {5'd9, 5'd13, 5'd4, 3'd2});
      for (int k = 0; k < 16; k++)
         chk("s4_bk", {cap_a[64+k], cap_b[64+k], cap_tw[64+k], cap_s[64+k]},
             {5'(k), 5'(k + 16), 5'(k), 3'd4});
      chk("gap0_done_cycle", 64'(g0_cyc), 64'd81);
      chk("gap3_done_cycle", 64'(g3_cyc), 64'd93);

      // random stalls, start poked while busy and with done
      run(1'b1, 1'b1, 1'b1, 0);

      // reset in the middle of stage 2, then a clean run
      run(1'b0, 1'b0, 1'b0, 42);
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("post_reset_idle", {bus.busy, bus.bf_valid}, 64'd0);
      cap_n = 0;
      run(1'b0, 1'b0, 1'b0, 0);
      chk("bf_count_after_reset", 64'(cap_n), 64'd80);

      chk("queue_empty", 64'(q.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/fft_twiddle_addr_gen.md
# fft_twiddle_addr_gen

Sequencer for the radix-2 DIT FFT core. It walks every stage and butterfly of an N-point transform and drives the shared address of the real and imaginary twiddle ROMs, which are 1-cycle registered reads. Alongside each twiddle it emits the butterfly operand indices, time-aligned with the ROM outputs, so the downstream butterfly unit receives indices, stage and twiddle data together.

## Interface
- LOG2N, 5, log2 of transform size N (N=32 by default)
- ADDR_W, 5, twiddle ROM address width; must be ≥ LOG2N-1
- STAGE_GAP, 2, idle cycles inserted between stages for butterfly write-back (0 allowed)

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a transform; sampled only in IDLE
- ready  in  1  butterfly unit can accept a new butterfly in the next cycle
- tw_addr  out  ADDR_W  twiddle exponent k (W_N^k) to both twiddle ROMs
- bf_valid  out  1  indices/stage valid; aligned with ROM data_out
- bf_idx_a  out  LOG2N  upper operand index
- bf_idx_b  out  LOG2N  lower operand index
- bf_stage  out  3  stage number 0..LOG2N-1
- busy  out  1  transform in progress
- done  out  1  single-cycle completion pulse

## Operation
- States: IDLE, RUN, GAP. Counters: stage s (0..LOG2N-1), butterfly b (0..N/2-1), gap g.
- IDLE: start=1 → RUN, s=0, b=0. start while busy is ignored.
- RUN, issue = ready: present address for (s,b); advance b on the next edge. If ready=0, hold s, b and tw_addr; no issue.
- Per butterfly: half=2^s, p=b & (half-1), j=b>>s; idx_a=(j<<(s+1))|p; idx_b=idx_a+half; tw_addr=p<<(LOG2N-1-s), zero-extended to ADDR_W.
- After issue of b=N/2-1: if s<LOG2N-1 → GAP (or RUN with s+1, b=0 directly if STAGE_GAP=0); else → IDLE.
- GAP: g counts STAGE_GAP cycles regardless of ready, then RUN with s+1, b=0, g=0.
- Output pipe: bf_valid, bf_idx_a, bf_idx_b, bf_stage are registered copies of issue/idx/s from the previous cycle, so they coincide with ROM data_out for that tw_addr.
- done=1 in the cycle carrying the final bf_valid (s=LOG2N-1, b=N/2-1).
- busy=1 from the cycle after start is accepted through the cycle in which done=1.

## Timing
- Reset (async, any state incl. mid-transform): state IDLE, all counters 0, tw_addr=0, bf_valid=0, bf_idx_a=0, bf_idx_b=0, bf_stage=0, busy=0, done=0. In-flight butterflies are discarded; bf_valid is never asserted after reset until a new start.
- Latency: start sampled at edge E0; first tw_addr valid in cycle 1; first bf_valid in cycle 2.
- ready=1 throughout, defaults: N/2·LOG2N + STAGE_GAP·(LOG2N-1) = 88 issue/gap cycles (cycles 1..88); final bf_valid and done in cycle 89; busy low in cycle 90.
- ready=0 for k RUN cycles extends completion by exactly k cycles; ready=0 during GAP has no effect.
- bf_valid drops in the cycle after any ready=0 issue slot; bf_* payload holds its last value while bf_valid=0.
- start asserted in the same cycle as done: ignored; a new transform needs start in IDLE.
- tw_addr stays constant during stalls so ROM data_out remains stable.

## Test plan
- Reset mid-RUN (stage 2): rst_n low → all outputs 0 in the same cycle; after release, no bf_valid until start; a fresh start yields full 80-butterfly sequence.
- Full run, ready=1: exactly 80 bf_valid pulses, done at cycle 89, busy 1..89; stage 0 first pairs (0,1),(2,3) with tw_addr=0; stage 2 b=5 → idx (9,13), tw_addr=4; stage 4 b=k → (k,k+16), tw_addr=k.
- Random ready stalls (~30% low): sequence of (idx_a,idx_b,tw_addr,stage) identical to unstalled run; done delayed by number of RUN stall cycles; tw_addr constant across stalls.
- ROM alignment: connect real and imaginary twiddle ROMs; check each bf_valid cycle's ROM data equals the table entry for the tw_addr issued one cycle earlier.
- STAGE_GAP=0 and STAGE_GAP=3: stage transitions back-to-back vs 3 idle cycles; totals 81 and 93 cycles to done.
- start pulsed while busy and coincident with done: ignored; no restart, counters unchanged.
